// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter that owns a T flip-flop: each grant pulses T for one cycle, then a HOLD_CYCLES cooldown.
// Optional toggle counter built only when TFF_ARB_COUNT_EN is defined (otherwise toggle_count reads 0).
module tff_toggle_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            t_out,
  output logic            q,
  output logic            busy,
  output logic [15:0]     toggle_count
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COOLDOWN} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt, w_win;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [3:0]      r_cd, w_cd_nxt;
  logic            r_tout, r_q;
  logic            w_found, w_arb;
  int              w_idx;

  // First set request at or above the pointer, wrapping past NREQ-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end

  // An edge that would land in IDLE also arbitrates, so back-to-back grants lose no cycle.
  assign w_arb = (r_state == S_IDLE) ||
                 ((r_state == S_GRANT) && (HOLD_CYCLES == 0)) ||
                 ((r_state == S_COOLDOWN) && (r_cd == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_ptr_nxt   = r_ptr;
    w_cd_nxt    = r_cd;
    case (r_state)
      S_GRANT: begin
        if (HOLD_CYCLES > 0) begin
          w_state_nxt = S_COOLDOWN;
          w_cd_nxt    = 4'(HOLD_CYCLES - 1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COOLDOWN: begin
        if (r_cd == 4'd0) w_state_nxt = S_IDLE;
        else              w_cd_nxt    = r_cd - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_arb && w_found) begin
      w_state_nxt = S_GRANT;
      w_gnt_nxt   = NREQ'(1) << w_win;
      w_ptr_nxt   = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= '0;
      r_tout <= 1'b0;
      r_ptr  <= '0;
      r_cd   <= '0;
      r_q    <= 1'b0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_tout <= |w_gnt_nxt;
      r_ptr  <= w_ptr_nxt;
      r_cd   <= w_cd_nxt;
      if (r_state == S_GRANT) r_q <= ~r_q;
    end
  end

`ifdef TFF_ARB_COUNT_EN
  logic [15:0] r_toggle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_toggle_cnt <= 16'h0000;
    else if (r_state == S_GRANT) r_toggle_cnt <= r_toggle_cnt + 16'd1;
  end

  assign toggle_count = r_toggle_cnt;
`else
  assign toggle_count = 16'h0000;
`endif

  assign gnt   = r_gnt;
  assign t_out = r_tout;
  assign q     = r_q;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed bench: dut2 runs with a 2-cycle cooldown, dut0 with none; shared clock and reset.
module tb_tff_toggle_arbiter;

`ifdef TFF_ARB_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req2 = 4'b0000, req0 = 4'b0000;
  logic [3:0]  gnt2, gnt0;
  logic        t2, t0, q2, q0, busy2, busy0;
  logic [15:0] cnt2, cnt0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  tff_toggle_arbiter #(.NREQ(4), .HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .gnt(gnt2), .t_out(t2),
    .q(q2), .busy(busy2), .toggle_count(cnt2));

  tff_toggle_arbiter #(.NREQ(4), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .t_out(t0),
    .q(q0), .busy(busy0), .toggle_count(cnt0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req2  = 4'b1111;
    req0  = 4'b1111;
    #1;
    for (int i = 0; i < 3; i++) begin
      if ({gnt2, t2, q2, busy2} !== 7'b0000000) begin n_fail++; $display("FAIL reset_dut2: got %b expected %b", {gnt2, t2, q2, busy2}, 7'b0000000); end
      n_chk++;
      if ({gnt0, t0, q0, busy0} !== 7'b0000000) begin n_fail++; $display("FAIL reset_dut0: got %b expected %b", {gnt0, t0, q0, busy0}, 7'b0000000); end
      n_chk++;
      if (cnt2 !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", cnt2); end
      n_chk++;
      tick();
    end
    req2  = 4'b0000;
    req0  = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req2 = 4'b0100;
    tick();
    if ({gnt2, t2, q2, busy2} !== 7'b0100101) begin n_fail++; $display("FAIL single_grant: got %b expected %b", {gnt2, t2, q2, busy2}, 7'b0100101); end
    n_chk++;
    req2 = 4'b0000;
    tick();
    if ({gnt2, t2, q2, busy2} !== 7'b0000011) begin n_fail++; $display("FAIL single_toggle: got %b expected %b", {gnt2, t2, q2, busy2}, 7'b0000011); end
    n_chk++;
    if (cnt2 !== (CNT_EN ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", cnt2, CNT_EN ? 1 : 0); end
    n_chk++;
    tick();
    if (busy2 !== 1'b1) begin n_fail++; $display("FAIL single_busy3: got %b expected 1", busy2); end
    n_chk++;
    tick();
    if ({busy2, q2} !== 2'b01) begin n_fail++; $display("FAIL single_idle: got %b expected 01", {busy2, q2}); end
    n_chk++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic       exp_q;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req2 = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      exp_g = 4'b0001 << (g % 4);
      exp_q = g[0];
      if ({gnt2, t2, q2} !== {exp_g, 1'b1, exp_q}) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", g, {gnt2, t2, q2}, {exp_g, 1'b1, exp_q}); end
      n_chk++;
      tick();
      if ({t2, q2} !== {1'b0, ~exp_q}) begin n_fail++; $display("FAIL rr_toggle%0d: got %b expected %b", g, {t2, q2}, {1'b0, ~exp_q}); end
      n_chk++;
      tick();
      if (t2 !== 1'b0) begin n_fail++; $display("FAIL rr_gap%0d: got %b expected 0", g, t2); end
      n_chk++;
    end
    if (cnt2 !== (CNT_EN ? 16'd5 : 16'd0)) begin n_fail++; $display("FAIL rr_count: got %0d expected %0d", cnt2, CNT_EN ? 5 : 0); end
    n_chk++;
    req2 = 4'b0000;
    tick();
    if ({busy2, q2} !== 2'b01) begin n_fail++; $display("FAIL rr_idle: got %b expected 01", {busy2, q2}); end
    n_chk++;
  endtask

  task automatic test_cooldown_ignore();
    req2 = 4'b0001;
    tick();
    if (gnt2 !== 4'b0001) begin n_fail++; $display("FAIL cd_wrap_grant: got %b expected 0001", gnt2); end
    n_chk++;
    req2 = 4'b0000;
    tick();
    req2 = 4'b0010;
    tick();
    req2 = 4'b0000;
    if ({gnt2, t2, q2, busy2} !== 7'b0000001) begin n_fail++; $display("FAIL cd_ignore: got %b expected %b", {gnt2, t2, q2, busy2}, 7'b0000001); end
    n_chk++;
    tick();
    tick();
    if ({gnt2, t2, q2, busy2} !== 7'b0000000) begin n_fail++; $display("FAIL cd_after: got %b expected %b", {gnt2, t2, q2, busy2}, 7'b0000000); end
    n_chk++;
  endtask

  task automatic test_back_to_back();
    logic exp_q;
    req0 = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_q = i[0];
      if ({gnt0, t0, q0} !== {4'b0001, 1'b1, exp_q}) begin n_fail++; $display("FAIL b2b_pulse%0d: got %b expected %b", i, {gnt0, t0, q0}, {4'b0001, 1'b1, exp_q}); end
      n_chk++;
    end
    req0 = 4'b0000;
    tick();
    if ({gnt0, t0, q0, busy0} !== 7'b0000000) begin n_fail++; $display("FAIL b2b_end: got %b expected %b", {gnt0, t0, q0, busy0}, 7'b0000000); end
    n_chk++;
    if (cnt0 !== (CNT_EN ? 16'd4 : 16'd0)) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", cnt0, CNT_EN ? 4 : 0); end
    n_chk++;
  endtask

  task automatic test_reset_mid();
    req2 = 4'b0100;
    tick();
    req2 = 4'b0000;
    if ({gnt2, t2} !== 5'b01001) begin n_fail++; $display("FAIL mid_pre: got %b expected 01001", {gnt2, t2}); end
    n_chk++;
    #2;
    rst_n = 1'b0;
    #1;
    if ({gnt2, t2, q2, busy2} !== 7'b0000000) begin n_fail++; $display("FAIL mid_async: got %b expected %b", {gnt2, t2, q2, busy2}, 7'b0000000); end
    n_chk++;
    tick();
    if ({q2, cnt2} !== 17'h00000) begin n_fail++; $display("FAIL mid_discard: got %h expected 00000", {q2, cnt2}); end
    n_chk++;
    rst_n = 1'b1;
    req2  = 4'b1010;
    tick();
    req2 = 4'b0000;
    if ({gnt2, t2} !== 5'b00101) begin n_fail++; $display("FAIL mid_ptr0: got %b expected 00101", {gnt2, t2}); end
    n_chk++;
    tick();
    if (q2 !== 1'b1) begin n_fail++; $display("FAIL mid_toggle: got %b expected 1", q2); end
    n_chk++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_cooldown_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
